// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one block memory between the icache and dcache miss ports
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);
  typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D} state_t;
  state_t            state_q;
  logic              last_grant_q, seen_busy_q;
  logic [DATA_W-1:0] rd_buf_q;
  logic              req_i, req_d, g_i, g_d, done;
  assign req_i = i_read;
  assign req_d = d_read | d_write;
  assign g_i   = state_q == GRANT_I;
  assign g_d   = state_q == GRANT_D;
  assign done  = seen_busy_q & ~mem_busywait;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      seen_busy_q  <= 1'b0;
      rd_buf_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_d && (!req_i || !last_grant_q)) begin
            state_q      <= GRANT_D;
            last_grant_q <= 1'b1;
            seen_busy_q  <= 1'b0;
          end else if (req_i) begin
            state_q      <= GRANT_I;
            last_grant_q <= 1'b0;
            seen_busy_q  <= 1'b0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_busywait) seen_busy_q <= 1'b1;
          if (done) begin
            if (mem_read) rd_buf_q <= mem_readdata;
            state_q <= g_i ? DONE_I : DONE_D;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mem_read      = g_i | (g_d & d_read & ~d_write);
  assign mem_write     = g_d & d_write;
  assign mem_address   = g_i ? i_address : g_d ? d_address : '0;
  assign mem_writedata = g_d ? d_writedata : '0;
  assign i_busywait    = req_i & (state_q != DONE_I);
  assign d_busywait    = req_d & (state_q != DONE_D);
  assign i_readdata    = rd_buf_q;
  assign d_readdata    = rd_buf_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests of mem_arbiter against a behavioural block memory with fixed latency
module tb_mem_arbiter;
  localparam int LAT = 5;
  localparam logic [127:0] WD1 = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
  localparam logic [127:0] WD2 = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
  logic         clock, reset;
  logic         i_read, i_busywait, d_read, d_write, d_busywait;
  logic [5:0]   i_address, d_address, mem_address;
  logic [127:0] i_readdata, d_readdata, d_writedata, mem_writedata, mem_readdata;
  logic         mem_read, mem_write, mem_busywait;
  int           pass_cnt = 0, total = 0;
  logic [127:0] mem [64];
  logic         busy, fin;
  int           cnt;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [127:0] pat(input logic [5:0] a);
    logic [7:0] b;
    b = 8'hA0 + {2'b00, a};
    return {16{b}};
  endfunction

  // Memory raises busywait the edge after a strobe, holds it LAT cycles, then idles until strobes drop.
  assign mem_busywait = busy;
  always @(posedge clock) begin
    if (reset) begin
      busy <= 1'b0;
      fin  <= 1'b0;
      cnt  <= 0;
      mem_readdata <= '0;
      for (int k = 0; k < 64; k++) mem[k] <= pat(6'(k));
    end else if (busy) begin
      if (cnt == 1) begin
        busy <= 1'b0;
        fin  <= 1'b1;
        if (mem_write) mem[mem_address] <= mem_writedata;
        else mem_readdata <= mem[mem_address];
      end else cnt <= cnt - 1;
    end else if (fin) begin
      if (!mem_read && !mem_write) fin <= 1'b0;
    end else if (mem_read || mem_write) begin
      busy <= 1'b1;
      cnt  <= LAT;
    end
  end

  task automatic test_reset;
    reset = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_writedata = '0;
    repeat (2) @(negedge clock);
    total++; if (mem_read !== 1'b0) $display("FAIL rst_mem_read got %b want 0", mem_read); else pass_cnt++;
    total++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write got %b want 0", mem_write); else pass_cnt++;
    total++; if (mem_address !== 6'h00) $display("FAIL rst_mem_address got %h want 00", mem_address); else pass_cnt++;
    total++; if (mem_writedata !== 128'h0) $display("FAIL rst_mem_writedata got %h want 0", mem_writedata); else pass_cnt++;
    total++; if ({i_busywait, d_busywait} !== 2'b00) $display("FAIL rst_busywait got %b want 00", {i_busywait, d_busywait}); else pass_cnt++;
    total++; if (i_readdata !== 128'h0) $display("FAIL rst_readdata got %h want 0", i_readdata); else pass_cnt++;
    i_read = 1'b1;
    #1;
    total++; if (i_busywait !== 1'b1) $display("FAIL rst_busy_follows got %b want 1", i_busywait); else pass_cnt++;
    i_read = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_icache_read;
    int cyc = 0;
    bit ok = 1'b1;
    i_address = 6'h05; i_read = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (!i_busywait) begin cyc = c; break; end
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 6'h05) ok = 1'b0;
    end
    total++; if (cyc != LAT + 3) $display("FAIL i_latency got %0d want %0d", cyc, LAT + 3); else pass_cnt++;
    total++; if (!ok) $display("FAIL i_strobe got dropped want mem_read held"); else pass_cnt++;
    total++; if (i_readdata !== pat(6'h05)) $display("FAIL i_readdata got %h want %h", i_readdata, pat(6'h05)); else pass_cnt++;
    total++; if (mem_read !== 1'b0) $display("FAIL i_done_strobe got %b want 0", mem_read); else pass_cnt++;
    @(negedge clock);
    total++; if (i_busywait !== 1'b1) $display("FAIL i_low_once got %b want 1", i_busywait); else pass_cnt++;
    i_read = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_dcache_write;
    int cyc = 0;
    bit ok = 1'b1;
    d_address = 6'h3F; d_writedata = WD1; d_write = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (!d_busywait) begin cyc = c; break; end
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 6'h3F || mem_writedata !== WD1) ok = 1'b0;
    end
    total++; if (cyc != LAT + 3) $display("FAIL d_wr_latency got %0d want %0d", cyc, LAT + 3); else pass_cnt++;
    total++; if (!ok) $display("FAIL d_wr_strobe got wrong mem drive want write of %h to 3F", WD1); else pass_cnt++;
    total++; if (mem[63] !== WD1) $display("FAIL d_wr_mem got %h want %h", mem[63], WD1); else pass_cnt++;
    total++; if (d_readdata !== pat(6'h05)) $display("FAIL d_wr_rdbuf got %h want %h", d_readdata, pat(6'h05)); else pass_cnt++;
    total++; if (mem_write !== 1'b0) $display("FAIL d_wr_done_strobe got %b want 0", mem_write); else pass_cnt++;
    @(negedge clock);
    total++; if (d_busywait !== 1'b1) $display("FAIL d_wr_low_once got %b want 1", d_busywait); else pass_cnt++;
    d_write = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_tie(input bit d_first, input string name);
    int td = 0, ti = 0;
    logic [127:0] rd_d = '0, rd_i = '0;
    d_address = 6'h10; i_address = 6'h21;
    d_read = 1'b1; i_read = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clock);
      if (td == 0 && !d_busywait) begin td = c; rd_d = d_readdata; d_read = 1'b0; end
      if (ti == 0 && !i_busywait) begin ti = c; rd_i = i_readdata; i_read = 1'b0; end
      if (td != 0 && ti != 0) break;
    end
    d_read = 1'b0; i_read = 1'b0;
    total++; if (td != (d_first ? LAT + 3 : 2 * LAT + 7)) $display("FAIL %s d_done got %0d want %0d", name, td, d_first ? LAT + 3 : 2 * LAT + 7); else pass_cnt++;
    total++; if (ti != (d_first ? 2 * LAT + 7 : LAT + 3)) $display("FAIL %s i_done got %0d want %0d", name, ti, d_first ? 2 * LAT + 7 : LAT + 3); else pass_cnt++;
    total++; if (rd_d !== pat(6'h10)) $display("FAIL %s d_data got %h want %h", name, rd_d, pat(6'h10)); else pass_cnt++;
    total++; if (rd_i !== pat(6'h21)) $display("FAIL %s i_data got %h want %h", name, rd_i, pat(6'h21)); else pass_cnt++;
    @(negedge clock);
  endtask

  task automatic test_rw_both;
    int cyc = 0;
    bit ok = 1'b1;
    d_address = 6'h2A; d_writedata = WD2; d_read = 1'b1; d_write = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (!d_busywait) begin cyc = c; break; end
      if (mem_write !== 1'b1 || mem_read !== 1'b0) ok = 1'b0;
    end
    total++; if (cyc != LAT + 3) $display("FAIL rw_latency got %0d want %0d", cyc, LAT + 3); else pass_cnt++;
    total++; if (!ok) $display("FAIL rw_strobe got read issued want write only"); else pass_cnt++;
    total++; if (mem[42] !== WD2) $display("FAIL rw_mem got %h want %h", mem[42], WD2); else pass_cnt++;
    total++; if (d_readdata !== pat(6'h21)) $display("FAIL rw_rdbuf got %h want %h", d_readdata, pat(6'h21)); else pass_cnt++;
    d_read = 1'b0; d_write = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid;
    int cyc = 0;
    i_address = 6'h07; i_read = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (mem_read !== 1'b1) $display("FAIL mid_pre_strobe got %b want 1", mem_read); else pass_cnt++;
    reset = 1'b1;
    @(negedge clock);
    total++; if (mem_read !== 1'b0) $display("FAIL mid_strobe got %b want 0", mem_read); else pass_cnt++;
    total++; if (i_readdata !== 128'h0) $display("FAIL mid_rdbuf got %h want 0", i_readdata); else pass_cnt++;
    total++; if (i_busywait !== 1'b1) $display("FAIL mid_busy got %b want 1", i_busywait); else pass_cnt++;
    reset = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (!i_busywait) begin cyc = c; break; end
    end
    total++; if (cyc != LAT + 3) $display("FAIL mid_retry_latency got %0d want %0d", cyc, LAT + 3); else pass_cnt++;
    total++; if (i_readdata !== pat(6'h07)) $display("FAIL mid_retry_data got %h want %h", i_readdata, pat(6'h07)); else pass_cnt++;
    i_read = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    test_reset;
    test_icache_read;
    test_dcache_write;
    test_tie(1'b0, "tie_after_d");
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    test_tie(1'b1, "tie_after_reset");
    test_rw_both;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
